vga_pixel_gen: RTL and testbench

Pixel generator stage that sits directly downstream of the VGA sync generator. It consumes the raw timing (`video_on`, `hsync`, `vsync`, `pixel_x`, `pixel_y`) and draws a solid rectangle that bounces inside the active area over a background. It drives registered 12-bit RGB plus sync outputs delayed to match the RGB latency. The box position advances once per frame, on the falling edge of `vsync`.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_pixel_gen_if.sv | 25 ++
 rtl/vga_box_mover.sv | 72 +++++++
 rtl/vga_pixel_gen.sv | 104 ++++++++++
 tb/tb_vga_pixel_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel generator: colour and direction types,
// default active-area sizes, the comparison width and the colour-bar palette.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 255;
    localparam int V_ACTIVE_DEF = 480;
    localparam int CMP_W        = 11;

    typedef logic [11:0] rgb_t;

    // FWD is RIGHT on the X axis and DOWN on the Y axis.
    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_t;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_pixel_gen_if.sv
// Timing-in / video-out bundle between the sync generator, the pixel generator and the DAC side.
interface vga_pixel_gen_if;

    logic           run;
    logic           video_on;
    logic           hsync;
    logic           vsync;
    logic [8:0]     pixel_x;
    logic [9:0]     pixel_y;
    vga_pkg::rgb_t  rgb;
    logic           hsync_o;
    logic           vsync_o;
    logic           frame_tick;

    modport master (
        output run, video_on, hsync, vsync, pixel_x, pixel_y,
        input  rgb, hsync_o, vsync_o, frame_tick
    );

    modport slave (
        input  run, video_on, hsync, vsync, pixel_x, pixel_y,
        output rgb, hsync_o, vsync_o, frame_tick
    );

endinterface

// File: rtl/vga_box_mover.sv
// One axis of the bouncing box: position plus a FWD/REV direction FSM that steps once per
// qualified frame tick, clamping to the edge and reversing in the same update.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int EXTENT = H_ACTIVE_DEF,
    parameter int SIZE   = 16,
    parameter int STEP   = 1,
    parameter int POS_W  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             run,
    output logic [POS_W-1:0] pos,
    output dir_t             dir
);

    localparam logic [CMP_W-1:0] EXT_W  = CMP_W'(EXTENT);
    localparam logic [CMP_W-1:0] SIZE_W = CMP_W'(SIZE);
    localparam logic [CMP_W-1:0] STEP_W = CMP_W'(STEP);
    localparam logic [CMP_W-1:0] LIMIT  = CMP_W'(EXTENT - SIZE);

    dir_t             dir_q, dir_n;
    logic [POS_W-1:0] pos_q, pos_n;
    logic [CMP_W-1:0] pos_w;

    assign pos_w = CMP_W'(pos_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q <= FWD;
            pos_q <= '0;
        end else begin
            dir_q <= dir_n;
            pos_q <= pos_n;
        end
    end

    // NOTE: defaults first so every path assigns dir_n/pos_n and no latch is inferred.
    always_comb begin
        dir_n = dir_q;
        pos_n = pos_q;
        if (tick && run) begin
            unique case (dir_q)
                FWD: begin
                    if (pos_w + SIZE_W + STEP_W <= EXT_W) begin
                        pos_n = POS_W'(pos_w + STEP_W);
                    end else begin
                        pos_n = POS_W'(LIMIT);
                        dir_n = REV;
                    end
                end
                REV: begin
                    if (pos_w >= STEP_W) begin
                        pos_n = POS_W'(pos_w - STEP_W);
                    end else begin
                        pos_n = '0;
                        dir_n = FWD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pos = pos_q;
        dir = dir_q;
    end

endmodule

// File: rtl/vga_pixel_gen.sv
// Two-stage pixel generator drawing a bouncing box over a background, with syncs delayed to match.
// Define VGA_PIX_BARS_EN to replace the flat background with eight vertical colour bars.
module vga_pixel_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   BOX_W     = 16,
    parameter int   BOX_H     = 32,
    parameter int   STEP_X    = 1,
    parameter int   STEP_Y    = 2,
    parameter rgb_t BOX_COLOR = 12'hF00,
    parameter rgb_t BG_COLOR  = 12'h00F
) (
    input logic            clk,
    input logic            reset,
    vga_pixel_gen_if.slave vif
);

    logic [8:0]       box_x;
    logic [9:0]       box_y;
    dir_t             dir_x, dir_y;
    logic             vsync_d, frame_tick_q;
    logic [CMP_W-1:0] px, py, bx, by;
    logic             hit;
    logic             von_s1, hs_s1, vs_s1, hit_s1;
    rgb_t             bg, rgb_q;
    logic             hs_s2, vs_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_d      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            vsync_d      <= vif.vsync;
            frame_tick_q <= vsync_d & ~vif.vsync;
        end
    end

    vga_box_mover #(.EXTENT(H_ACTIVE), .SIZE(BOX_W), .STEP(STEP_X), .POS_W(9)) u_mover_x (
        .clk   (clk),
        .reset (reset),
        .tick  (frame_tick_q),
        .run   (vif.run),
        .pos   (box_x),
        .dir   (dir_x)
    );

    vga_box_mover #(.EXTENT(V_ACTIVE), .SIZE(BOX_H), .STEP(STEP_Y), .POS_W(10)) u_mover_y (
        .clk   (clk),
        .reset (reset),
        .tick  (frame_tick_q),
        .run   (vif.run),
        .pos   (box_y),
        .dir   (dir_y)
    );

    // Widened to CMP_W so box_x + BOX_W cannot wrap near the right/bottom edge.
    assign px  = CMP_W'(vif.pixel_x);
    assign py  = CMP_W'(vif.pixel_y);
    assign bx  = CMP_W'(box_x);
    assign by  = CMP_W'(box_y);
    assign hit = (px >= bx) && (px < bx + CMP_W'(BOX_W)) &&
                 (py >= by) && (py < by + CMP_W'(BOX_H));

`ifdef VGA_PIX_BARS_EN
    logic [2:0] bar_idx_s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bar_idx_s1 <= '0;
        else        bar_idx_s1 <= vif.pixel_x[7:5];
    end

    assign bg = bar_color(bar_idx_s1);
`else
    assign bg = BG_COLOR;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            von_s1 <= 1'b0;
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
            hit_s1 <= 1'b0;
            rgb_q  <= '0;
            hs_s2  <= 1'b1;
            vs_s2  <= 1'b1;
        end else begin
            von_s1 <= vif.video_on;
            hs_s1  <= vif.hsync;
            vs_s1  <= vif.vsync;
            hit_s1 <= hit;
            rgb_q  <= !von_s1 ? rgb_t'(0) : (hit_s1 ? BOX_COLOR : bg);
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
        end
    end

    assign vif.rgb        = rgb_q;
    assign vif.hsync_o    = hs_s2;
    assign vif.vsync_o    = vs_s2;
    assign vif.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Self-checking bench: two pixel generators (STEP_X 1 and 3) driven with identical timing and
// compared against a frame-level model of box position and pixel colour.
module tb_vga_pixel_gen;
    import vga_pkg::*;

    localparam int   H    = 255;
    localparam int   V    = 480;
    localparam int   BW   = 16;
    localparam int   BH   = 32;
    localparam rgb_t BOXC = 12'hF00;
    localparam rgb_t BGC  = 12'h00F;

    logic       clk = 1'b0;
    logic       reset;
    logic       run, video_on, hsync, vsync;
    logic [8:0] pixel_x;
    logic [9:0] pixel_y;

    vga_pixel_gen_if if_a();
    vga_pixel_gen_if if_b();

    assign if_a.run      = run;
    assign if_a.video_on = video_on;
    assign if_a.hsync    = hsync;
    assign if_a.vsync    = vsync;
    assign if_a.pixel_x  = pixel_x;
    assign if_a.pixel_y  = pixel_y;
    assign if_b.run      = run;
    assign if_b.video_on = video_on;
    assign if_b.hsync    = hsync;
    assign if_b.vsync    = vsync;
    assign if_b.pixel_x  = pixel_x;
    assign if_b.pixel_y  = pixel_y;

    vga_pixel_gen u_a (.clk(clk), .reset(reset), .vif(if_a.slave));
    vga_pixel_gen #(.STEP_X(3)) u_b (.clk(clk), .reset(reset), .vif(if_b.slave));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: index 0 is u_a, index 1 is u_b; fx/fy = 1 means moving right/down.
    int bx[2];
    int by[2];
    bit fx[2];
    bit fy[2];
    int sx[2] = '{1, 3};

    function automatic int next_pos(int p, bit fwd, int ext, int size, int step);
        if (fwd) return (p + size + step <= ext) ? p + step : ext - size;
        return (p >= step) ? p - step : 0;
    endfunction

    function automatic bit next_fwd(int p, bit fwd, int ext, int size, int step);
        if (fwd) return (p + size + step <= ext);
        return (p < step);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            bx[d] = 0; by[d] = 0; fx[d] = 1'b1; fy[d] = 1'b1;
        end
    endfunction

    function automatic void model_advance();
        int nx, ny;
        for (int d = 0; d < 2; d++) begin
            nx    = next_pos(bx[d], fx[d], H, BW, sx[d]);
            fx[d] = next_fwd(bx[d], fx[d], H, BW, sx[d]);
            bx[d] = nx;
            ny    = next_pos(by[d], fy[d], V, BH, 2);
            fy[d] = next_fwd(by[d], fy[d], V, BH, 2);
            by[d] = ny;
        end
    endfunction

    function automatic rgb_t bg_of(int x);
`ifdef VGA_PIX_BARS_EN
        int   bar;
        rgb_t c;
        bar = (x / 32) % 8;
        c   = 12'h000;
        if (bar >= 4)     c = c | 12'hF00;
        if ((bar / 2) % 2 == 1) c = c | 12'h0F0;
        if (bar % 2 == 1) c = c | 12'h00F;
        return c;
`else
        return BGC;
`endif
    endfunction

    function automatic rgb_t exp_rgb(int d, int x, int y, bit von);
        if (!von) return 12'h000;
        if (x >= bx[d] && x < bx[d] + BW && y >= by[d] && y < by[d] + BH) return BOXC;
        return bg_of(x);
    endfunction

    function automatic rgb_t dut_rgb(int d);
        return (d == 0) ? if_a.rgb : if_b.rgb;
    endfunction

    function automatic logic dut_tick(int d);
        return (d == 0) ? if_a.frame_tick : if_b.frame_tick;
    endfunction

    function automatic logic dut_hs(int d);
        return (d == 0) ? if_a.hsync_o : if_b.hsync_o;
    endfunction

    function automatic logic dut_vs(int d);
        return (d == 0) ? if_a.vsync_o : if_b.vsync_o;
    endfunction

    task automatic drive(input int x, input int y, input bit von);
        pixel_x  = 9'(x);
        pixel_y  = 10'(y);
        video_on = von;
    endtask

    task automatic probe(input string name, input int x, input int y, input bit von);
        rgb_t e;
        @(negedge clk);
        drive(x, y, von);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e = exp_rgb(d, x, y, von);
            vectors++;
            if (dut_rgb(d) !== e) begin
                miscompares++;
                $display("FAIL %s dut%0d pixel(%0d,%0d) von=%0b rgb=%h expected=%h box=(%0d,%0d)",
                         name, d, x, y, von, dut_rgb(d), e, bx[d], by[d]);
            end
        end
    endtask

    task automatic probe_box(input int d);
        probe("box_top_left", bx[d], by[d], 1'b1);
        probe("box_bottom_right", bx[d] + BW - 1, by[d] + BH - 1, 1'b1);
        probe("box_right_outside", bx[d] + BW, by[d], 1'b1);
        probe("box_below_outside", bx[d], by[d] + BH, 1'b1);
        if (bx[d] > 0) probe("box_left_outside", bx[d] - 1, by[d], 1'b1);
        if (by[d] > 0) probe("box_above_outside", bx[d], by[d] - 1, 1'b1);
    endtask

    task automatic do_frame(input bit r);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dut_tick(d) !== 1'b0) begin
                miscompares++;
                $display("FAIL tick_idle dut%0d frame_tick=%b expected=0", d, dut_tick(d));
            end
        end
        run = r; video_on = 1'b0; vsync = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dut_tick(d) !== 1'b1) begin
                miscompares++;
                $display("FAIL tick_pulse dut%0d frame_tick=%b expected=1", d, dut_tick(d));
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dut_tick(d) !== 1'b0) begin
                miscompares++;
                $display("FAIL tick_single dut%0d frame_tick=%b expected=0", d, dut_tick(d));
            end
        end
        if (r) model_advance();
        vsync = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 1) begin
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if (dut_rgb(d) !== 12'h000 || dut_hs(d) !== 1'b1 ||
                        dut_vs(d) !== 1'b1 || dut_tick(d) !== 1'b0) begin
                        miscompares++;
                        $display("FAIL reset_values dut%0d rgb=%h hs=%b vs=%b tick=%b expected 000/1/1/0",
                                 d, dut_rgb(d), dut_hs(d), dut_vs(d), dut_tick(d));
                    end
                end
            end
            drive($urandom_range(0, 511), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            run   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        hsync = 1'b1; vsync = 1'b1; run = 1'b0;
        reset = 1'b1;
        model_reset();
        probe("reset_origin", 0, 0, 1'b1);
    endtask

    task automatic test_first_frame();
        do_frame(1'b1);
        probe("first_frame_origin", 0, 0, 1'b1);
        probe("first_frame_box", 1, 2, 1'b1);
        probe_box(0);
        probe_box(1);
    endtask

    task automatic test_bounce();
        for (int f = 0; f < 500; f++) begin
            do_frame(1'b1);
            probe_box(0);
            probe_box(1);
            probe("random_pixel", $urandom_range(0, 511), $urandom_range(0, 1023),
                  1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_freeze();
        for (int f = 0; f < 6; f++) begin
            do_frame(1'b0);
            probe_box(0);
            probe_box(1);
        end
        for (int f = 0; f < 20; f++) begin
            do_frame(1'($urandom_range(0, 1)));
            probe_box(0);
            probe_box(1);
        end
    endtask

    task automatic test_back_to_back();
        int qx[$];
        int qy[$];
        bit qv[$];
        bit qh[$];
        int x, y;
        bit v, h;
        run = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (qx.size() >= 2) begin
                x = qx.pop_front(); y = qy.pop_front(); v = qv.pop_front(); h = qh.pop_front();
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if (dut_rgb(d) !== exp_rgb(d, x, y, v) || dut_hs(d) !== h) begin
                        miscompares++;
                        $display("FAIL back_to_back dut%0d pixel(%0d,%0d) rgb=%h hs=%b expected=%h/%b",
                                 d, x, y, dut_rgb(d), dut_hs(d), exp_rgb(d, x, y, v), h);
                    end
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                x = bx[0] + $urandom_range(0, BW + 3) - 2;
                y = by[0] + $urandom_range(0, BH + 3) - 2;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end else begin
                x = $urandom_range(0, 511);
                y = $urandom_range(0, 1023);
            end
            v = 1'($urandom_range(0, 3) != 0);
            h = 1'($urandom_range(0, 1));
            drive(x, y, v);
            hsync = h;
            qx.push_back(x); qy.push_back(y); qv.push_back(v); qh.push_back(h);
        end
        @(negedge clk);
        hsync = 1'b1;
    endtask

    task automatic test_blanking_sync();
        bit hq[$];
        bit vq[$];
        bit h, v;
        int low_cnt;
        low_cnt = 0;
        run = 1'b0;
        probe("blank_box_a", bx[0], by[0], 1'b0);
        probe("blank_box_b", bx[1], by[1], 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (hq.size() >= 2) begin
                h = hq.pop_front();
                v = vq.pop_front();
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if (dut_hs(d) !== h || dut_vs(d) !== v) begin
                        miscompares++;
                        $display("FAIL sync_delay dut%0d cycle %0d hs=%b vs=%b expected=%b/%b",
                                 d, i, dut_hs(d), dut_vs(d), h, v);
                    end
                end
            end
            if (if_a.hsync_o === 1'b0) low_cnt++;
            hsync = !(i >= 4 && i < 42);
            vsync = !(i >= 10 && i < 14);
            hq.push_back(hsync);
            vq.push_back(vsync);
        end
        vectors++;
        if (low_cnt != 38) begin
            miscompares++;
            $display("FAIL hsync_width low_cycles=%0d expected=38", low_cnt);
        end
        @(negedge clk);
        hsync = 1'b1; vsync = 1'b1;
        probe_box(0);
        probe_box(1);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(bx[0], by[0], 1'b1);
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dut_rgb(d) !== 12'h000 || dut_hs(d) !== 1'b1 ||
                dut_vs(d) !== 1'b1 || dut_tick(d) !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d rgb=%h hs=%b vs=%b tick=%b expected 000/1/1/0",
                         d, dut_rgb(d), dut_hs(d), dut_vs(d), dut_tick(d));
            end
        end
        @(negedge clk);
        hsync = 1'b1; vsync = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        probe("async_reset_origin", 0, 0, 1'b1);
        probe_box(0);
        probe_box(1);
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        drive(0, 0, 1'b0);
        model_reset();
        test_reset();
        test_first_frame();
        test_bounce();
        test_freeze();
        test_back_to_back();
        test_blanking_sync();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
